// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: jump opcodes, NOP word and fetch FSM states.
package mips_pkg;

   localparam logic [5:0]  OP_J   = 6'b000010;
   localparam logic [5:0]  OP_JAL = 6'b000011;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HOLD
   } fetch_state_e;

   // True for the unconditional J/JAL opcodes that fetch resolves on its own.
   function automatic logic is_jump(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for instruction fetch: redirect > stall > J/JAL > sequential.
module fetch_next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        stall_i,
   output logic [31:0] next_pc_o,
   output logic        latch_en_o
);

   logic [31:0] pc_plus4;
   logic        unused_br_lsbs;

   // Wraps naturally at 32 bits; the jump region bits come from here, not from pc.
   assign pc_plus4       = pc_i + 32'd4;
   assign unused_br_lsbs = ^br_target_i[1:0];

   // Priority select of the next fetch address and whether IF/ID captures the current word.
   always_comb begin
      next_pc_o  = pc_plus4;
      latch_en_o = 1'b0;
      if (br_taken_i) begin
         next_pc_o = {br_target_i[31:2], 2'b00};
      end else if (stall_i) begin
         next_pc_o = pc_i;
      end else if (is_jump(inst_i[31:26])) begin
         next_pc_o  = {pc_plus4[31:28], inst_i[25:0], 2'b00};
         latch_en_o = 1'b1;
      end else begin
         latch_en_o = 1'b1;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, drives the combinational instruction memory and
// captures each returned word into the IF/ID register. J/JAL redirect with no bubble; a
// downstream branch redirect costs exactly one bubble.
module inst_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] Address,
   input  logic [31:0] inst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic [31:0] link_addr
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  if_inst_q;
   logic [31:0]  if_pc_q;
   logic         if_valid_q;
   logic [31:0]  next_pc;
   logic         latch_en;

   fetch_next_pc u_next_pc (
      .pc_i        (pc_q),
      .inst_i      (inst),
      .br_taken_i  (br_taken),
      .br_target_i (br_target),
      .stall_i     (stall),
      .next_pc_o   (next_pc),
      .latch_en_o  (latch_en)
   );

   // Fetch FSM, PC and IF/ID register; every field returns to its reset value asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         if_inst_q  <= NOP;
         if_pc_q    <= RESET_PC;
         if_valid_q <= 1'b0;
      end else begin
         pc_q <= next_pc;
         if (br_taken) begin
            // Word at the current pc is wrong-path; leave a bubble behind it.
            if_valid_q <= 1'b0;
         end else if (latch_en) begin
            if_inst_q  <= inst;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
         end
         // A redirect overrides stall, so it always lands in RUN.
         unique case (state_q)
            BOOT:    state_q <= (stall && !br_taken) ? HOLD : RUN;
            RUN:     state_q <= (stall && !br_taken) ? HOLD : RUN;
            HOLD:    state_q <= (stall && !br_taken) ? HOLD : RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign Address   = pc_q;
   assign if_inst   = if_inst_q;
   assign if_pc     = if_pc_q;
   assign if_valid  = if_valid_q;
   assign link_addr = if_pc_q + 32'd4;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed walk of the fetch scenarios followed by random
// stall/redirect/reset traffic, all checked against an instruction-level reference model.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Address, inst, br_target, if_inst, if_pc, link_addr;
   logic        stall, br_taken, if_valid;
   logic [31:0] addr2, inst2, if_inst2, if_pc2, link2;
   logic        if_valid2;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:63];

   // Reference model state: architectural view only.
   logic [31:0] m_pc, m_if_inst, m_if_pc;
   logic        m_valid;

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a < 32'd256) return mem[a[7:2]];
      return {6'b100011, a[25:0]};
   endfunction

   always_comb inst  = word(Address);
   always_comb inst2 = word(addr2);

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .Address   (Address),
      .inst      (inst),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_target (br_target),
      .if_inst   (if_inst),
      .if_pc     (if_pc),
      .if_valid  (if_valid),
      .link_addr (link_addr)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk       (clk),
      .rst       (rst),
      .Address   (addr2),
      .inst      (inst2),
      .stall     (1'b0),
      .br_taken  (1'b0),
      .br_target (32'h0),
      .if_inst   (if_inst2),
      .if_pc     (if_pc2),
      .if_valid  (if_valid2),
      .link_addr (link2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0;
      m_if_inst = 32'h0;
      m_if_pc   = 32'h0;
      m_valid   = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".Address"},   Address,   m_pc);
      chk({tag, ".if_inst"},   if_inst,   m_if_inst);
      chk({tag, ".if_pc"},     if_pc,     m_if_pc);
      chk({tag, ".if_valid"},  {31'b0, if_valid}, {31'b0, m_valid});
      chk({tag, ".link_addr"}, link_addr, m_if_pc + 32'd4);
   endtask

   // Apply inputs, clock once, advance the model by one instruction-level rule, then compare.
   task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t);
      logic [31:0] w;
      stall     = s;
      br_taken  = b;
      br_target = t;
      @(posedge clk);
      if (b) begin
         m_pc    = {t[31:2], 2'b00};
         m_valid = 1'b0;
      end else if (!s) begin
         w         = word(m_pc);
         m_if_inst = w;
         m_if_pc   = m_pc;
         m_valid   = 1'b1;
         if (w[31:26] == 6'd2 || w[31:26] == 6'd3) m_pc = {m_pc[31:28] + ((m_pc[27:0] == 28'hFFF_FFFC) ? 4'd1 : 4'd0), w[25:0], 2'b00};
         else m_pc = m_pc + 32'd4;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [31:0] w;
      // Random image: mostly non-jump words, some J/JAL targeting the mapped region.
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            w = {($urandom_range(0, 1) == 0) ? 6'd2 : 6'd3, 20'd0, 6'($urandom_range(0, 63))};
         end else if (w[31:26] == 6'd2 || w[31:26] == 6'd3) begin
            w[31:26] = 6'b100011;
         end
         mem[i] = w;
      end
      mem[0]  = 32'hAC00_0008;
      mem[1]  = 32'h2001_0001;
      mem[2]  = 32'h2002_0002;
      mem[3]  = 32'h2003_0003;
      mem[4]  = 32'h2004_0004;
      mem[5]  = 32'h0800_0020;
      mem[16] = 32'h2010_0010;
      mem[17] = 32'h2011_0011;
      mem[32] = 32'h2020_0020;
      mem[33] = 32'h0C00_0000;

      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      model_reset();
      #1;
      check_all("reset");
      chk("wrap.reset_addr", addr2, 32'hFFFF_FFFC);
      chk("wrap.reset_link", link2, 32'h0000_0000);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_hold");
      rst = 1'b0;

      // Sequential run 0..20, then J at 20 to 128.
      step("seq0", 1'b0, 1'b0, 32'h0);
      chk("first_valid.if_pc", if_pc, 32'h0);
      chk("first_valid.if_inst", if_inst, 32'hAC00_0008);
      chk("wrap.after_fetch_addr", addr2, 32'h0);
      chk("wrap.after_fetch_if_pc", if_pc2, 32'hFFFF_FFFC);
      chk("wrap.after_fetch_valid", {31'b0, if_valid2}, 32'd1);
      for (int i = 1; i < 6; i++) step("seq", 1'b0, 1'b0, 32'h0);
      chk("j.addr", Address, 32'd128);
      chk("j.if_pc", if_pc, 32'd20);
      step("j_next", 1'b0, 1'b0, 32'h0);
      chk("j_next.addr", Address, 32'd132);
      step("jal", 1'b0, 1'b0, 32'h0);
      chk("jal.if_pc", if_pc, 32'd132);
      chk("jal.link", link_addr, 32'd136);
      chk("jal.addr", Address, 32'd0);

      // Branch redirect at pc=8.
      step("to8a", 1'b0, 1'b0, 32'h0);
      step("to8b", 1'b0, 1'b0, 32'h0);
      chk("pre_br.addr", Address, 32'd8);
      step("br", 1'b0, 1'b1, 32'h0000_0043);
      chk("br.addr", Address, 32'd64);
      chk("br.bubble", {31'b0, if_valid}, 32'd0);
      step("br_after", 1'b0, 1'b0, 32'h0);
      chk("br_after.if_pc", if_pc, 32'd64);

      // Stall three cycles at pc=12.
      step("to0", 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) step("to12", 1'b0, 1'b0, 32'h0);
      chk("pre_stall.addr", Address, 32'd12);
      for (int i = 0; i < 3; i++) begin
         step("stall", 1'b1, 1'b0, 32'h0);
         chk("stall.addr", Address, 32'd12);
         chk("stall.if_pc", if_pc, 32'd8);
         chk("stall.if_inst", if_inst, 32'h2002_0002);
      end
      step("resume", 1'b0, 1'b0, 32'h0);
      chk("resume.if_pc", if_pc, 32'd12);
      chk("resume.addr", Address, 32'd16);
      step("stall_br", 1'b1, 1'b1, 32'h0000_0080);
      chk("stall_br.addr", Address, 32'd128);

      // Async reset in the middle of HOLD.
      step("hold", 1'b1, 1'b0, 32'h0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      stall = 1'b0;
      @(posedge clk);
      #1;
      check_all("async_rst_held");
      rst = 1'b0;
      step("post_rst", 1'b0, 1'b0, 32'h0);

      // Random traffic with occasional asynchronous reset pulses.
      for (int n = 0; n < 300; n++) begin
         step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              32'($urandom_range(0, 255)));
         if ($urandom_range(0, 49) == 0) begin
            #1 rst = 1'b1;
            #1;
            model_reset();
            check_all("rand_rst");
            rst = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end for the single-issue MIPS core. It owns the program counter and drives the byte address into the combinational instruction memory `IR`, which returns `inst` in the same cycle. It latches each returned word into the IF/ID register for the decoder. It also pre-decodes J/JAL so unconditional jumps redirect without decoder involvement, and it accepts branch redirects and stalls from downstream. There is no branch delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `Address`  out  32  byte address to instruction memory; always equals internal `pc`.
- `inst`  in  32  instruction word returned by memory for `Address`, valid in the same cycle.
- `stall`  in  1  hold: freeze pc and IF/ID register.
- `br_taken`  in  1  one-cycle redirect request from decode/execute.
- `br_target`  in  32  redirect address; bits [1:0] ignored (forced 0).
- `if_inst`  out  32  latched instruction for decode.
- `if_pc`  out  32  address of `if_inst`.
- `if_valid`  out  1  `if_inst` is a real instruction (0 = bubble).
- `link_addr`  out  32  `if_pc + 4`, meaningful when `if_inst` is JAL.

## Operation
- FSM states:
  - BOOT: entered on reset; lasts exactly one cycle after `rst` falls. Fetches `RESET_PC`, then goes to RUN. `stall` is honoured in BOOT.
  - RUN: normal fetch.
  - HOLD: entered when `stall`=1 at a posedge; stays while `stall`=1; returns to RUN on the first posedge with `stall`=0.
- Per-posedge priority, highest first:
  - `br_taken`:
    - pc <= {br_target[31:2],2'b00}.
    - if_valid <= 0, because the word at the current pc is wrong-path.
    - `stall` is ignored this cycle.
  - `stall`: pc, if_inst, if_pc, if_valid all hold.
  - Pre-decoded jump, when inst[31:26] is OP_J or OP_JAL:
    - latch if_inst <= inst, if_pc <= pc, if_valid <= 1.
    - pc <= {pc_plus4[31:28], inst[25:0], 2'b00}.
  - Sequential fetch:
    - latch if_inst <= inst, if_pc <= pc, if_valid <= 1.
    - pc <= pc + 4.
- Arithmetic:
  - pc_plus4 is a 32-bit add; 32'hFFFF_FFFC wraps to 0.
  - Jump region bits come from pc_plus4, not pc.
- `link_addr` = if_pc + 4, combinational from the register.
- A high-impedance or unknown `inst` (unmapped address) is latched as-is. It is not a jump; the decoder treats it as invalid.

## Timing
- Reset values:
  - pc = `RESET_PC`, so `Address` = `RESET_PC`.
  - if_inst = 32'h0000_0000 (NOP), if_pc = `RESET_PC`, if_valid = 0.
  - link_addr = `RESET_PC` + 4.
  - State = BOOT.
- Latency: word at address A appears on `if_inst` one cycle after pc = A.
- Throughput: one instruction per cycle with no stalls.
- Jump penalty: 0 bubbles. The jump itself is valid in IF/ID, and its target is fetched the next cycle.
- Branch penalty: exactly 1 bubble (if_valid=0) after `br_taken`.
- `rst` asserted mid-stall or mid-redirect: all state returns to reset values immediately, without waiting for a clock edge.
- Pending redirects are not remembered across reset.

## Structure
- Shared package `mips_pkg`:
  - OP_J=6'b000010, OP_JAL=6'b000011.
  - NOP=32'h0.
  - FSM state enum {BOOT, RUN, HOLD}.
- Sub-module `fetch_next_pc` (combinational): inputs pc, inst, br_taken, br_target, stall; output next_pc and a latch-enable. This keeps the priority logic unit-testable.

## Test plan
- Reset then run with memory image 0..20:
  - `Address` steps 0, 4, 8, 12, 16, 20.
  - if_valid first rises one cycle after reset release, with if_pc=0 and if_inst=32'hAC00_0008.
- J at 20 (32'h0800_0020):
  - The cycle after if_pc=20, `Address`=128 with no bubble.
  - The cycle after that, `Address`=132.
- JAL at 132 (32'h0C00_0000):
  - if_pc=132, link_addr=136.
  - Next `Address`=0.
- `br_taken`=1 with br_target=32'h0000_0043 while pc=8:
  - Next `Address`=64 and if_valid=0 for one cycle.
  - Then if_pc=64.
- `stall` high for 3 cycles at pc=12:
  - `Address`, if_pc and if_inst frozen for 3 cycles.
  - Then resumes at 16 with no lost or duplicated instruction.
  - `br_taken` during the stall overrides it.
- `rst` asserted asynchronously mid-HOLD:
  - Outputs return to reset values before the next posedge.
  - `RESET_PC`=32'hFFFF_FFFC wraps to 0 after one fetch.
